// File: rtl/psum_drain_engine_if.sv
// -----------------------------------------------------------------------------
// psum_drain_engine_if
// Bundles the job-control, OFIFO and PSUM SRAM signals of the partial-sum
// drain engine.
//
// Parameters: COL (lanes per vector), PSUM_BW (signed lane width),
//             ADDR_W (PSUM SRAM address width).
//
// Signals (direction as seen by the engine, i.e. the slave modport):
//   start        in   one-cycle job request
//   acc_mode     in   1 = read-add-write, 0 = overwrite
//   relu_en      in   1 = clamp negative lanes to zero
//   base_addr    in   first SRAM address of the job
//   num_vec      in   number of vectors in the job
//   ofifo_valid  in   OFIFO head word available
//   ofifo_out    in   OFIFO head word, lane k at [k*PSUM_BW +: PSUM_BW]
//   ofifo_rd     out  OFIFO pop strobe
//   pmem_cen     out  SRAM chip enable, active-low
//   pmem_wen     out  SRAM write enable, active-low
//   pmem_a       out  SRAM address
//   pmem_d       out  SRAM write data
//   pmem_q       in   SRAM read data, valid the cycle after a read
//   busy         out  engine not idle
//   done         out  one-cycle job completion pulse
// -----------------------------------------------------------------------------
interface psum_drain_engine_if #(
  parameter int COL     = 8,
  parameter int PSUM_BW = 16,
  parameter int ADDR_W  = 11
);
  logic                     start;
  logic                     acc_mode;
  logic                     relu_en;
  logic [ADDR_W-1:0]        base_addr;
  logic [ADDR_W-1:0]        num_vec;
  logic                     ofifo_valid;
  logic [COL*PSUM_BW-1:0]   ofifo_out;
  logic                     ofifo_rd;
  logic                     pmem_cen;
  logic                     pmem_wen;
  logic [ADDR_W-1:0]        pmem_a;
  logic [COL*PSUM_BW-1:0]   pmem_d;
  logic [COL*PSUM_BW-1:0]   pmem_q;
  logic                     busy;
  logic                     done;

  // The engine side.
  modport slave (
    input  start, acc_mode, relu_en, base_addr, num_vec,
    input  ofifo_valid, ofifo_out, pmem_q,
    output ofifo_rd, pmem_cen, pmem_wen, pmem_a, pmem_d, busy, done
  );

  // The controller / memory side.
  modport master (
    output start, acc_mode, relu_en, base_addr, num_vec,
    output ofifo_valid, ofifo_out, pmem_q,
    input  ofifo_rd, pmem_cen, pmem_wen, pmem_a, pmem_d, busy, done
  );
endinterface

// File: rtl/psum_drain_engine.sv
// -----------------------------------------------------------------------------
// psum_drain_engine
// Drains partial-sum vectors from the OFIFO into the PSUM SRAM. Each vector is
// either written as-is (overwrite) or added lane-wise to the word already held
// at the target address (accumulate), optionally clamped by ReLU.
//
// Ports:
//   clk    in  single clock, all state on the rising edge
//   reset  in  asynchronous, active-low reset
//   bus    psum_drain_engine_if.slave (job control, OFIFO, SRAM, status)
//
// Build option:
//   PSUM_SAT_EN  defined   -> lane sums saturate to the signed PSUM_BW range
//                undefined -> lane sums wrap modulo 2^PSUM_BW
//
// Per-vector sequence:
//   overwrite : WAIT_FIFO (pop) -> WRITE                    2 cycles
//   accumulate: WAIT_FIFO (pop + SRAM read) -> READ -> WRITE 3 cycles
// All SRAM/OFIFO strobes are decoded from the registered state, so an
// asynchronous reset returns every output to its idle value at once.
// -----------------------------------------------------------------------------
module psum_drain_engine #(
  parameter int COL     = 8,
  parameter int PSUM_BW = 16,
  parameter int ADDR_W  = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  psum_drain_engine_if.slave   bus
);

  localparam int VEC_W = COL * PSUM_BW;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_FIFO = 3'd1;
  localparam logic [2:0] S_READ      = 3'd2;
  localparam logic [2:0] S_WRITE     = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;

  logic [2:0]        r_state;
  logic [2:0]        w_state_next;

  // Job configuration, frozen at start.
  logic              r_acc_mode;
  logic              r_relu_en;
  logic [ADDR_W-1:0] r_base_addr;
  logic [ADDR_W-1:0] r_num_vec;

  logic [ADDR_W-1:0] r_index;
  logic [VEC_W-1:0]  r_vec;

  logic              w_pop;
  logic              w_rd;
  logic              w_wr;
  logic              w_last;
  logic [ADDR_W-1:0] w_addr;
  logic [VEC_W-1:0]  w_result;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  assign w_pop  = (r_state == S_WAIT_FIFO) && bus.ofifo_valid;
  assign w_rd   = w_pop && r_acc_mode;
  assign w_wr   = (r_state == S_WRITE);
  // Addition at ADDR_W bits gives the silent wrap past the top of the SRAM.
  assign w_addr = r_base_addr + r_index;
  assign w_last = (r_index == (r_num_vec - 1'b1));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_next = (bus.num_vec == '0) ? S_DONE : S_WAIT_FIFO;
        end
      end
      S_WAIT_FIFO: begin
        if (bus.ofifo_valid) begin
          w_state_next = r_acc_mode ? S_READ : S_WRITE;
        end
      end
      S_READ:  w_state_next = S_WRITE;
      S_WRITE: w_state_next = w_last ? S_DONE : S_WAIT_FIFO;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_acc_mode  <= 1'b0;
      r_relu_en   <= 1'b0;
      r_base_addr <= '0;
      r_num_vec   <= '0;
      r_index     <= '0;
      r_vec       <= '0;
    end else begin
      r_state <= w_state_next;

      // Start is only honoured in IDLE; later starts leave the job untouched.
      if ((r_state == S_IDLE) && bus.start) begin
        r_acc_mode  <= bus.acc_mode;
        r_relu_en   <= bus.relu_en;
        r_base_addr <= bus.base_addr;
        r_num_vec   <= bus.num_vec;
        r_index     <= '0;
      end

      if (w_pop) begin
        r_vec <= bus.ofifo_out;
      end

      if (w_wr && !w_last) begin
        r_index <= r_index + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Lane arithmetic: sum, overflow handling, then ReLU
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < COL; gi++) begin : g_lane
    logic [PSUM_BW-1:0] w_a;
    logic [PSUM_BW-1:0] w_b;
    logic [PSUM_BW-1:0] w_clip;

    assign w_a = r_vec[gi*PSUM_BW +: PSUM_BW];
    // pmem_q holds the word read in WAIT_FIFO through READ and WRITE.
    assign w_b = r_acc_mode ? bus.pmem_q[gi*PSUM_BW +: PSUM_BW] : '0;

`ifdef PSUM_SAT_EN
    logic [PSUM_BW:0] w_sum;

    // One guard bit: the two top bits differ exactly when the sum left the
    // signed range, and the guard bit then gives the direction.
    assign w_sum = {w_a[PSUM_BW-1], w_a} + {w_b[PSUM_BW-1], w_b};

    always_comb begin
      if (w_sum[PSUM_BW] != w_sum[PSUM_BW-1]) begin
        w_clip = w_sum[PSUM_BW] ? {1'b1, {(PSUM_BW-1){1'b0}}}
                                : {1'b0, {(PSUM_BW-1){1'b1}}};
      end else begin
        w_clip = w_sum[PSUM_BW-1:0];
      end
    end
`else
    // Two's-complement wrap modulo 2^PSUM_BW.
    assign w_clip = w_a + w_b;
`endif

    assign w_result[gi*PSUM_BW +: PSUM_BW] =
      (r_relu_en && w_clip[PSUM_BW-1]) ? '0 : w_clip;
  end

  // ---------------------------------------------------------------------------
  // Outputs; address and data are parked at zero whenever the SRAM is idle
  // ---------------------------------------------------------------------------
  assign bus.ofifo_rd = w_pop;
  assign bus.pmem_cen = !(w_rd || w_wr);
  assign bus.pmem_wen = !w_wr;
  assign bus.pmem_a   = (w_rd || w_wr) ? w_addr : '0;
  assign bus.pmem_d   = w_wr ? w_result : '0;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done     = (r_state == S_DONE);

endmodule
